// File: rtl/rf_wport_arb_pkg.sv
// Shared widths, arbiter state encodings and helpers
// for the register-file write-port arbiter.
package rf_wport_arb_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_HOLD  = 2'd1;
    localparam logic [1:0] ARB_FORCE = 2'd2;

    function automatic logic [3:0] wait_last(input int max_wait);
        return 4'(max_wait - 1);
    endfunction

endpackage

// File: rtl/rf_wport_arb_if.sv
// WB / LU / register-file bundle around the write-port arbiter.
// master drives requests, slave is the arbiter.
interface rf_wport_arb_if
    import rf_wport_arb_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
) ();

    logic              flush;

    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;

    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_dest;
    logic [DATA_W-1:0] lu_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wdest;
    logic [DATA_W-1:0] rf_wdata;

    logic              lu_pend;
    logic [ADDR_W-1:0] lu_pend_dest;
    logic              lu_drop;

    modport master (
        output flush,
        output wb_valid, wb_we, wb_dest, wb_data,
        input  wb_stall,
        output lu_valid, lu_dest, lu_data,
        input  lu_ready,
        input  rf_we, rf_wdest, rf_wdata,
        input  lu_pend, lu_pend_dest, lu_drop
    );

    modport slave (
        input  flush,
        input  wb_valid, wb_we, wb_dest, wb_data,
        output wb_stall,
        input  lu_valid, lu_dest, lu_data,
        output lu_ready,
        output rf_we, rf_wdest, rf_wdata,
        output lu_pend, lu_pend_dest, lu_drop
    );

endinterface

// File: rtl/rf_wport_arb_buf.sv
// One-entry holding register for a late long-latency result.
// A load never coincides with kill/drain since ready needs it empty.
module rf_wport_arb_buf
    import rf_wport_arb_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic              drain,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dest  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dest  <= in_dest;
            data  <= in_data;
        end else if (kill || drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB has priority, a buffered
// LU result drains in idle slots or forces a one-cycle WB stall.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input logic          clk,
    input logic          rst,
    rf_wport_arb_if.slave bus
);

    localparam logic [3:0] WAIT_LAST = wait_last(MAX_WAIT);

    logic              run;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_dest;
    logic [DATA_W-1:0] buf_data;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nx;

    logic in_hold;
    logic in_force;
    logic wb_claim;
    logic waw;
    logic drain;
    logic kill;
    logic accept;
    logic load;

    // Every output is forced low while reset is asserted.
    assign run      = ~rst;
    assign in_hold  = run & (state == ARB_HOLD);
    assign in_force = run & (state == ARB_FORCE);

    assign wb_claim = run & bus.wb_valid & bus.wb_we
                    & (bus.wb_dest != '0) & ~in_force;
    assign waw      = ~bus.flush & in_hold & wb_claim
                    & (bus.wb_dest == buf_dest);
    assign drain    = ~bus.flush
                    & ((in_hold & ~wb_claim) | in_force);
    assign kill     = bus.flush | waw;

    assign accept = bus.lu_valid & bus.lu_ready & ~bus.flush;
    assign load   = accept & (bus.lu_dest != '0);

    assign bus.wb_stall     = in_force;
    assign bus.lu_ready     = run & ~buf_valid;
    assign bus.lu_pend      = run & buf_valid;
    assign bus.lu_pend_dest = bus.lu_pend ? buf_dest : '0;
    assign bus.lu_drop      = run & ((bus.flush & buf_valid) | waw);

    rf_wport_arb_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .kill    (kill),
        .drain   (drain),
        .in_dest (bus.lu_dest),
        .in_data (bus.lu_data),
        .valid   (buf_valid),
        .dest    (buf_dest),
        .data    (buf_data)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_wdest = '0;
        bus.rf_wdata = '0;
        if (drain) begin
            bus.rf_we    = 1'b1;
            bus.rf_wdest = buf_dest;
            bus.rf_wdata = buf_data;
        end else if (wb_claim) begin
            bus.rf_we    = 1'b1;
            bus.rf_wdest = bus.wb_dest;
            bus.rf_wdata = bus.wb_data;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        if (bus.flush) begin
            state_nx = ARB_IDLE;
            wait_nx  = '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (load) state_nx = ARB_HOLD;
                end
                ARB_HOLD: begin
                    if (!wb_claim || waw) begin
                        state_nx = ARB_IDLE;
                        wait_nx  = '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nx = ARB_FORCE;
                        wait_nx  = '0;
                    end else begin
                        wait_nx = wait_cnt + 4'd1;
                    end
                end
                ARB_FORCE: begin
                    state_nx = ARB_IDLE;
                    wait_nx  = '0;
                end
                default: begin
                    state_nx = ARB_IDLE;
                    wait_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: reset, drain, starvation force,
// WAW kill, flush, r0 handling and reset mid-operation.
module tb_rf_wport_arb;
    import rf_wport_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rf_wport_arb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_wport_arb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_dest  = '0;
        bus.wb_data  = '0;
        bus.lu_valid = 1'b0;
        bus.lu_dest  = '0;
        bus.lu_data  = '0;
    endtask

    task automatic wb(input logic [4:0] d, input logic [31:0] v);
        bus.wb_valid = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_dest  = d;
        bus.wb_data  = v;
    endtask

    task automatic lu(input logic [4:0] d, input logic [31:0] v);
        bus.lu_valid = 1'b1;
        bus.lu_dest  = d;
        bus.lu_data  = v;
    endtask

    task automatic chk_rf(input string tag, input logic we,
                          input logic [4:0] d, input logic [31:0] v);
        chk({tag, "_we"}, 32'(bus.rf_we), 32'(we));
        chk({tag, "_dest"}, 32'(bus.rf_wdest), 32'(d));
        chk({tag, "_data"}, bus.rf_wdata, v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_rf(tag, 1'b0, 5'd0, 32'h0);
        chk({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
        chk({tag, "_ready"}, 32'(bus.lu_ready), 32'd0);
        chk({tag, "_pend"}, 32'(bus.lu_pend), 32'd0);
        chk({tag, "_pdest"}, 32'(bus.lu_pend_dest), 32'd0);
        chk({tag, "_drop"}, 32'(bus.lu_drop), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        quiet();

        // 1: reset held with LU offering and WB writing
        for (int i = 0; i < 3; i++) begin
            cyc();
            lu(5'd5, 32'h1111);
            wb(5'd2, 32'h2222);
            #1;
            chk_all_zero("rst");
        end
        cyc();
        rst = 1'b0;
        quiet();
        #1;
        chk("rst_rel_ready", 32'(bus.lu_ready), 32'd1);
        chk("rst_rel_we", 32'(bus.rf_we), 32'd0);

        // 2: LU r5 drains one cycle after accept
        cyc();
        lu(5'd5, 32'h1234);
        #1;
        chk("t2_acc_ready", 32'(bus.lu_ready), 32'd1);
        chk("t2_no_bypass", 32'(bus.rf_we), 32'd0);
        cyc();
        quiet();
        #1;
        chk_rf("t2_drain", 1'b1, 5'd5, 32'h1234);
        chk("t2_pend", 32'(bus.lu_pend), 32'd1);
        chk("t2_pdest", 32'(bus.lu_pend_dest), 32'd5);
        chk("t2_busy", 32'(bus.lu_ready), 32'd0);
        cyc();
        #1;
        chk("t2_ready_again", 32'(bus.lu_ready), 32'd1);
        chk("t2_idle_we", 32'(bus.rf_we), 32'd0);
        chk("t2_idle_pend", 32'(bus.lu_pend), 32'd0);

        // 3: starvation forces a drain after four lost slots
        cyc();
        lu(5'd5, 32'h0055);
        #1;
        cyc();
        quiet();
        wb(5'd7, 32'h77);
        #1;
        chk_rf("t3_c1", 1'b1, 5'd7, 32'h77);
        chk("t3_c1_stall", 32'(bus.wb_stall), 32'd0);
        cyc();
        wb(5'd8, 32'h88);
        #1;
        chk_rf("t3_c2", 1'b1, 5'd8, 32'h88);
        cyc();
        wb(5'd9, 32'h99);
        #1;
        chk_rf("t3_c3", 1'b1, 5'd9, 32'h99);
        cyc();
        wb(5'd10, 32'hAA0);
        #1;
        chk_rf("t3_c4", 1'b1, 5'd10, 32'hAA0);
        chk("t3_c4_stall", 32'(bus.wb_stall), 32'd0);
        chk("t3_c4_pdest", 32'(bus.lu_pend_dest), 32'd5);
        cyc();
        wb(5'd11, 32'hBB1);
        #1;
        chk("t3_c5_stall", 32'(bus.wb_stall), 32'd1);
        chk_rf("t3_c5", 1'b1, 5'd5, 32'h0055);
        cyc();
        #1;
        chk("t3_c6_stall", 32'(bus.wb_stall), 32'd0);
        chk_rf("t3_c6", 1'b1, 5'd11, 32'hBB1);
        chk("t3_c6_pend", 32'(bus.lu_pend), 32'd0);

        // 4: younger WB write to the same register kills the LU result
        cyc();
        quiet();
        lu(5'd6, 32'hDEAD);
        #1;
        cyc();
        quiet();
        wb(5'd6, 32'hAA);
        #1;
        chk_rf("t4_waw", 1'b1, 5'd6, 32'hAA);
        chk("t4_drop", 32'(bus.lu_drop), 32'd1);
        cyc();
        quiet();
        #1;
        chk_rf("t4_after", 1'b0, 5'd0, 32'h0);
        chk("t4_drop_end", 32'(bus.lu_drop), 32'd0);
        chk("t4_pend", 32'(bus.lu_pend), 32'd0);

        // 5: flush discards buffer but keeps the WB write
        cyc();
        lu(5'd3, 32'h3333);
        #1;
        cyc();
        quiet();
        bus.flush = 1'b1;
        wb(5'd4, 32'h44);
        #1;
        chk_rf("t5_flush", 1'b1, 5'd4, 32'h44);
        chk("t5_drop", 32'(bus.lu_drop), 32'd1);
        cyc();
        quiet();
        #1;
        chk("t5_pend", 32'(bus.lu_pend), 32'd0);
        chk("t5_we", 32'(bus.rf_we), 32'd0);
        chk("t5_drop_end", 32'(bus.lu_drop), 32'd0);

        // flush with an empty buffer: no drop pulse
        cyc();
        bus.flush = 1'b1;
        #1;
        chk("t5b_drop", 32'(bus.lu_drop), 32'd0);

        // 6: r0 destinations are never written or buffered
        cyc();
        quiet();
        lu(5'd0, 32'hFF);
        wb(5'd0, 32'hEE);
        #1;
        chk("t6_we", 32'(bus.rf_we), 32'd0);
        chk("t6_ready", 32'(bus.lu_ready), 32'd1);
        cyc();
        quiet();
        #1;
        chk("t6_pend", 32'(bus.lu_pend), 32'd0);
        chk("t6_we2", 32'(bus.rf_we), 32'd0);
        chk("t6_ready2", 32'(bus.lu_ready), 32'd1);

        // reset mid-operation loses the result silently
        cyc();
        lu(5'd9, 32'h9999);
        #1;
        cyc();
        quiet();
        rst = 1'b1;
        #1;
        chk_all_zero("t7_rst");
        cyc();
        rst = 1'b0;
        #1;
        chk("t7_pend", 32'(bus.lu_pend), 32'd0);
        chk("t7_we", 32'(bus.rf_we), 32'd0);
        chk("t7_ready", 32'(bus.lu_ready), 32'd1);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
